cmp_eqge_serial: RTL and testbench

Sequential, digit-serial equality and magnitude comparator: accepts two unsigned operands over a valid/ready handshake and scans them one digit per cycle from the most significant digit downward. It stops at the first differing digit and returns EQ = (A == B), GE = (A >= B) and the number of digits examined. It sits alongside the parallel prefix comparators as the area-optimised, MSB-first, early-terminating alternative for multi-cycle datapaths.

---
 rtl/cmp_eqge_serial.sv | 199 +++++++++++++++++++
 tb/tb_cmp_eqge_serial.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cmp_eqge_serial.sv
// -----------------------------------------------------------------------------
// cmp_eqge_serial
//
// Digit-serial unsigned comparator. An operand pair is accepted over a
// valid/ready handshake, then scanned one digit per cycle starting at the most
// significant digit. The scan stops at the first differing digit (or after
// digit 0) and reports A == B, A >= B and how many digits were examined.
//
// Parameters
//   width    operand width in bits
//   digit    bits compared per cycle; width must be a multiple of digit
//
// Ports
//   CLK       clock, rising edge
//   RST       synchronous active-high reset
//   InValid   operand pair valid
//   InReady   block can accept an operand pair (state decode only)
//   A, B      unsigned operands, sampled only on the accept edge
//   OutValid  result valid (state decode of a register)
//   OutReady  consumer accepts result
//   EQ        A == B
//   GE        A >= B
//   Steps     digits examined, 1..N
// -----------------------------------------------------------------------------
module cmp_eqge_serial #(
  parameter  int width = 8,
  parameter  int digit = 1,
  localparam int N     = width / digit,
  localparam int SW    = $clog2(N + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              InValid,
  output logic              InReady,
  input  logic [width-1:0]  A,
  input  logic [width-1:0]  B,
  output logic              OutValid,
  input  logic              OutReady,
  output logic              EQ,
  output logic              GE,
  output logic [SW-1:0]     Steps
);

  // Digit index width; a single-digit configuration still needs one bit.
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  generate
    if (digit < 1 || (width % digit) != 0) begin : g_bad_cfg
      $error("cmp_eqge_serial: width must be a positive multiple of digit");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;

  logic [width-1:0]    a_q;
  logic [width-1:0]    b_q;
  logic [IW-1:0]       idx;

  logic [digit-1:0]    dig_a;
  logic [digit-1:0]    dig_b;
  logic                dig_ne;
  logic                dig_gt;
  logic                last_dig;
  logic                accept;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Extract digit number i of a word. Shifting and truncating keeps the
  // variable select simple and free of out-of-range part-select forms.
  function automatic logic [digit-1:0] digit_of(input logic [width-1:0] word,
                                                input logic [IW-1:0]    i);
    logic [width-1:0] sh;
    sh       = word >> (i * digit);
    digit_of = sh[digit-1:0];
  endfunction

  // Unsigned compare of one digit pair: {differ, a_greater}.
  function automatic logic [1:0] digit_cmp(input logic [digit-1:0] da,
                                           input logic [digit-1:0] db);
    digit_cmp = {(da != db), (da > db)};
  endfunction

  // ---------------------------------------------------------------------------
  // Current-digit compare (combinational, from latched operands)
  // ---------------------------------------------------------------------------
  always_comb begin
    dig_a             = digit_of(a_q, idx);
    dig_b             = digit_of(b_q, idx);
    {dig_ne, dig_gt}  = digit_cmp(dig_a, dig_b);
    last_dig          = (idx == '0);
  end

  assign accept = (state == IDLE) && InValid;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (InValid) begin
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        // Early exit on the first differing digit, otherwise stop after digit 0.
        if (dig_ne || last_dig) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        // Handoff returns to IDLE; a new accept can only follow next cycle.
        if (OutReady) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode (state register only, no input paths)
  // ---------------------------------------------------------------------------
  always_comb begin
    InReady  = 1'b0;
    OutValid = 1'b0;
    case (state)
      IDLE:    InReady  = 1'b1;
      DONE:    OutValid = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand capture: data only, no reset needed
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (accept) begin
      a_q <= A;
      b_q <= B;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan control and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      idx   <= '0;
      Steps <= '0;
      EQ    <= 1'b0;
      GE    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (InValid) begin
            idx   <= IW'(N - 1);
            Steps <= '0;
          end
        end
        SCAN: begin
          Steps <= Steps + 1'b1;
          if (dig_ne) begin
            EQ <= 1'b0;
            GE <= dig_gt;
          end else if (last_dig) begin
            EQ <= 1'b1;
            GE <= 1'b1;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: ;  // DONE holds the result stable under back-pressure
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_eqge_serial.sv
module tb_cmp_eqge_serial;

  logic        clk;
  logic        rst;

  // width 8, digit 1
  logic        iv8, rdy8, ov8, or8, eq8, ge8;
  logic [7:0]  a8, b8;
  logic [3:0]  steps8;

  // width 16, digit 4
  logic        iv16, rdy16, ov16, or16, eq16, ge16;
  logic [15:0] a16, b16;
  logic [2:0]  steps16;

  int nvec;
  int nerr;

  cmp_eqge_serial #(.width(8), .digit(1)) dut8 (
    .CLK(clk), .RST(rst),
    .InValid(iv8), .InReady(rdy8), .A(a8), .B(b8),
    .OutValid(ov8), .OutReady(or8),
    .EQ(eq8), .GE(ge8), .Steps(steps8)
  );

  cmp_eqge_serial #(.width(16), .digit(4)) dut16 (
    .CLK(clk), .RST(rst),
    .InValid(iv16), .InReady(rdy16), .A(a16), .B(b16),
    .OutValid(ov16), .OutReady(or16),
    .EQ(eq16), .GE(ge16), .Steps(steps16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference leading-digit count for 16/4.
  function automatic int ref_k16(input logic [15:0] a, input logic [15:0] b);
    int k;
    k = 0;
    for (int d = 3; d >= 0; d--) begin
      k++;
      if (a[d*4 +: 4] != b[d*4 +: 4]) return k;
    end
    return k;
  endfunction

  // One full 8-bit operation with OutReady held high.
  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input int exp_eq, input int exp_ge, input int exp_k);
    int lat;
    int w;
    w = 0;
    while (!rdy8 && w < 20) begin tick(); w++; end
    chk({tag, ".rdy"}, int'(rdy8), 1);
    a8 = a; b8 = b; iv8 = 1'b1; or8 = 1'b1;
    tick();
    iv8 = 1'b0;
    a8 = ~a; b8 = ~b;  // later changes must have no effect
    lat = 0;
    while (!ov8 && lat < 40) begin tick(); lat++; end
    chk({tag, ".lat"}, lat, exp_k);
    chk({tag, ".eq"}, int'(eq8), exp_eq);
    chk({tag, ".ge"}, int'(ge8), exp_ge);
    chk({tag, ".steps"}, int'(steps8), exp_k);
    tick();
    chk({tag, ".post_rdy"}, int'(rdy8), 1);
    chk({tag, ".post_ov"}, int'(ov8), 0);
  endtask

  // One full 16-bit operation with OutReady held high; latency, EQ, GE, Steps.
  task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b);
    int lat;
    int k;
    int w;
    k = ref_k16(a, b);
    w = 0;
    while (!rdy16 && w < 20) begin tick(); w++; end
    a16 = a; b16 = b; iv16 = 1'b1; or16 = 1'b1;
    tick();
    iv16 = 1'b0;
    lat = 0;
    while (!ov16 && lat < 40) begin tick(); lat++; end
    chk({tag, ".lat"}, lat, k);
    chk({tag, ".eq"}, int'(eq16), int'(a == b));
    chk({tag, ".ge"}, int'(ge16), int'(a >= b));
    chk({tag, ".steps"}, int'(steps16), k);
    tick();
  endtask

  initial begin
    logic       s_eq, s_ge;
    logic [3:0] s_steps;
    int         lat;

    nvec = 0;
    nerr = 0;
    rst = 1'b1;
    iv8 = 1'b0; or8 = 1'b1; a8 = '0; b8 = '0;
    iv16 = 1'b0; or16 = 1'b1; a16 = '0; b16 = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst.rdy",   int'(rdy8),   1);
    chk("rst.ov",    int'(ov8),    0);
    chk("rst.eq",    int'(eq8),    0);
    chk("rst.ge",    int'(ge8),    0);
    chk("rst.steps", int'(steps8), 0);
    chk("rst16.rdy", int'(rdy16),  1);

    // Directed 8/1 vectors
    run8("v80_7f", 8'h80, 8'h7F, 0, 1, 1);
    run8("v5a_5a", 8'h5A, 8'h5A, 1, 1, 8);
    run8("v10_11", 8'h10, 8'h11, 0, 0, 8);
    run8("v00_ff", 8'h00, 8'hFF, 0, 0, 1);

    // Back-pressure: 0x33 vs 0x30 differ first at bit 1 -> k=7, GE=1
    or8 = 1'b0;
    a8 = 8'h33; b8 = 8'h30; iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    lat = 0;
    while (!ov8 && lat < 40) begin tick(); lat++; end
    chk("bp.lat", lat, 7);
    s_eq = eq8; s_ge = ge8; s_steps = steps8;
    chk("bp.eq", int'(s_eq), 0);
    chk("bp.ge", int'(s_ge), 1);
    chk("bp.steps", int'(s_steps), 7);
    for (int c = 0; c < 5; c++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); iv8 = c[0];
      tick();
      chk("bp.hold_ov",    int'(ov8),    1);
      chk("bp.hold_rdy",   int'(rdy8),   0);
      chk("bp.hold_eq",    int'(eq8),    int'(s_eq));
      chk("bp.hold_ge",    int'(ge8),    int'(s_ge));
      chk("bp.hold_steps", int'(steps8), int'(s_steps));
    end
    // Handoff edge with InValid high: must land in IDLE, not accept.
    iv8 = 1'b1; or8 = 1'b1;
    tick();
    iv8 = 1'b0;
    chk("bp.handoff_rdy", int'(rdy8), 1);
    chk("bp.handoff_ov",  int'(ov8),  0);
    tick();
    chk("bp.idle_ov", int'(ov8), 0);

    // Reset mid-SCAN of 0x01 vs 0x00 (k=8)
    a8 = 8'h01; b8 = 8'h00; iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    tick();
    tick();
    tick();
    chk("mrst.in_scan_rdy", int'(rdy8), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst.rdy",   int'(rdy8),   1);
    chk("mrst.ov",    int'(ov8),    0);
    chk("mrst.eq",    int'(eq8),    0);
    chk("mrst.ge",    int'(ge8),    0);
    chk("mrst.steps", int'(steps8), 0);
    run8("vff_ff", 8'hFF, 8'hFF, 1, 1, 8);

    // 16/4 configuration
    run16("w16.3c00_3d00", 16'h3C00, 16'h3D00);
    chk("w16.3c00_3d00.k", int'(steps16), 2);
    chk("w16.3c00_3d00.ge_abs", int'(ge16), 0);
    run16("w16.eq", 16'hBEEF, 16'hBEEF);
    run16("w16.lsd", 16'h1234, 16'h1233);
    for (int r = 0; r < 10000; r++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      // Bias a share of pairs toward long equal prefixes.
      case (r % 4)
        1: rb[15:4]  = ra[15:4];
        2: rb[15:8]  = ra[15:8];
        3: rb        = ra;
        default: ;
      endcase
      run16("w16.rand", ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
